// File: rtl/ctrl_pipe_stage_if.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_stage_if
// Bundles the decode-stage signals between IF/ID, the control stage and ID/EX.
//   master : drives the instruction in ID (id_valid, opcode, func, id_rs,
//            id_rt, id_rd) and flush; observes stall, the ex_* bundle and the
//            multiply/divide status (md_busy, md_done).
//   slave  : the control stage itself (ctrl_pipe_stage).
// ----------------------------------------------------------------------------
interface ctrl_pipe_stage_if #(
    parameter int ALUOP_W = 4,
    parameter int RADDR_W = 5
);
    logic               id_valid;
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic [RADDR_W-1:0] id_rd;
    logic               flush;

    logic               stall;
    logic               ex_valid;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_alusrc;
    logic               ex_regdst;
    logic               ex_regwrite;
    logic               ex_writemem;
    logic               ex_readmem;
    logic               ex_memtoreg;
    logic               ex_signextend;
    logic               ex_branch;
    logic [1:0]         ex_shift;
    logic [1:0]         ex_pc_source;
    logic [RADDR_W-1:0] ex_rt;
    logic [RADDR_W-1:0] ex_rd;
    logic               md_busy;
    logic               md_done;

    modport master (
        output id_valid, opcode, func, id_rs, id_rt, id_rd, flush,
        input  stall, ex_valid, ex_aluop, ex_alusrc, ex_regdst, ex_regwrite,
               ex_writemem, ex_readmem, ex_memtoreg, ex_signextend, ex_branch,
               ex_shift, ex_pc_source, ex_rt, ex_rd, md_busy, md_done
    );

    modport slave (
        input  id_valid, opcode, func, id_rs, id_rt, id_rd, flush,
        output stall, ex_valid, ex_aluop, ex_alusrc, ex_regdst, ex_regwrite,
               ex_writemem, ex_readmem, ex_memtoreg, ex_signextend, ex_branch,
               ex_shift, ex_pc_source, ex_rt, ex_rd, md_busy, md_done
    );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_stage
// Registered decode stage of the pipelined MIPS core. Decodes opcode/func into
// the control bundle and latches it into the ID/EX control register, detects
// load-use and multiply/divide hazards, honours flushes, and tracks MULT/DIV
// occupancy of EX with a busy counter.
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : ctrl_pipe_stage_if.slave -- ID inputs, flush, stall, ex_* bundle,
//          md_busy / md_done
// ----------------------------------------------------------------------------
module ctrl_pipe_stage #(
    parameter int ALUOP_W    = 4,
    parameter int RADDR_W    = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_pipe_stage_if.slave bus
);
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(10);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                           OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                           OP_BGTZ  = 6'h07, OP_ADDI   = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_ANDI   = 6'h0C, OP_ORI  = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW     = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03,
                           F_JR   = 6'h08, F_MFHI  = 6'h10, F_MFLO = 6'h12,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A,
                           F_DIVU = 6'h1B, F_ADD   = 6'h20, F_ADDU = 6'h21,
                           F_SUB  = 6'h22, F_SUBU  = 6'h23, F_AND  = 6'h24,
                           F_OR   = 6'h25, F_NOR   = 6'h27, F_SLT  = 6'h2A;

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regdst;
        logic               regwrite;
        logic               writemem;
        logic               readmem;
        logic               memtoreg;
        logic               signextend;
        logic               branch;
        logic [1:0]         shift;
        logic [1:0]         pc_source;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
    } ex_ctrl_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    ex_ctrl_t   dec, ex_d, ex_q;
    logic       uses_rt, is_mul, is_div, is_mf;
    logic       load_use, md_hazard, stall, ex_load, md_start, md_done;
    md_state_e  state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, md_len;

    // Instruction decode. A bundle with valid=0 is the all-zero bubble.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        uses_rt   = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mf     = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                uses_rt      = 1'b1;
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                case (bus.func)
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_NOR:         dec.aluop = ALU_NOR;
                    F_SLT:         dec.aluop = ALU_SLT;
                    F_SLL: begin dec.aluop = ALU_SLL; dec.shift = 2'b01; end
                    F_SRL: begin dec.aluop = ALU_SRL; dec.shift = 2'b10; end
                    F_SRA: begin dec.aluop = ALU_SRA; dec.shift = 2'b11; end
                    F_JR: begin
                        dec.regdst    = 1'b0;
                        dec.regwrite  = 1'b0;
                        dec.pc_source = 2'b11;
                    end
                    F_MULT, F_MULTU: begin
                        dec.regdst   = 1'b0;
                        dec.regwrite = 1'b0;
                        is_mul       = 1'b1;
                    end
                    F_DIV, F_DIVU: begin
                        dec.regdst   = 1'b0;
                        dec.regwrite = 1'b0;
                        is_div       = 1'b1;
                    end
                    F_MFHI, F_MFLO: is_mf = 1'b1;
                    default: dec.valid = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.signextend = 1'b1;
            end
            OP_SLTI: begin
                dec.aluop = ALU_SLT; dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.signextend = 1'b1;
            end
            OP_ANDI: begin dec.aluop = ALU_AND; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            OP_ORI:  begin dec.aluop = ALU_OR;  dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            OP_LUI:  begin dec.aluop = ALU_LUI; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            OP_LW: begin
                dec.aluop    = ALU_ADD; dec.alusrc  = 1'b1; dec.regwrite   = 1'b1;
                dec.readmem  = 1'b1;    dec.memtoreg = 1'b1; dec.signextend = 1'b1;
            end
            OP_SW: begin
                uses_rt      = 1'b1;
                dec.aluop    = ALU_ADD; dec.alusrc = 1'b1;
                dec.writemem = 1'b1;    dec.signextend = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGTZ, OP_REGIMM: begin
                uses_rt        = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);
                dec.aluop      = ALU_SUB;
                dec.signextend = 1'b1;
                dec.branch     = 1'b1;
                dec.pc_source  = 2'b01;
            end
            OP_J:   dec.pc_source = 2'b10;
            OP_JAL: begin dec.regwrite = 1'b1; dec.pc_source = 2'b10; end
            default: dec.valid = 1'b0;
        endcase

        if (dec.valid) begin
            dec.rt = bus.id_rt;
            dec.rd = bus.id_rd;
        end else begin
            dec    = '0;
            is_mul = 1'b0;
            is_div = 1'b0;
            is_mf  = 1'b0;
        end
    end

    // A register number of zero never carries a load result, so it is excluded.
    assign load_use = bus.id_valid && ex_q.valid && ex_q.readmem && (ex_q.rt != '0) &&
                      ((ex_q.rt == bus.id_rs) || (uses_rt && (ex_q.rt == bus.id_rt)));

    // The result is bypassed in the md_done cycle, so dependents issue there.
    assign md_hazard = bus.id_valid && (state_q == MD_BUSY) && (is_mul || is_div || is_mf) &&
                       !md_done;

    // Flush overrides any hazard: the instruction in ID is dead anyway.
    assign stall    = (load_use || md_hazard) && !bus.flush;
    assign ex_load  = bus.id_valid && !bus.flush && !stall;
    assign ex_d     = ex_load ? dec : '0;
    assign md_start = ex_load && (is_mul || is_div);
    assign md_len   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    assign md_done  = (state_q == MD_BUSY) && (count_q == '0);

    // Flush is deliberately absent: an operation already in BUSY is committed.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    count_d = md_len;
                end
            end
            MD_BUSY: begin
                if (count_q == '0) begin
                    // A stalled MULT/DIV issues in the done cycle and restarts the unit.
                    if (md_start) count_d = md_len;
                    else          state_d = MD_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            state_q <= MD_IDLE;
            count_q <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_aluop      = ex_q.aluop;
    assign bus.ex_alusrc     = ex_q.alusrc;
    assign bus.ex_regdst     = ex_q.regdst;
    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_writemem   = ex_q.writemem;
    assign bus.ex_readmem    = ex_q.readmem;
    assign bus.ex_memtoreg   = ex_q.memtoreg;
    assign bus.ex_signextend = ex_q.signextend;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_shift      = ex_q.shift;
    assign bus.ex_pc_source  = ex_q.pc_source;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.md_busy       = (state_q == MD_BUSY);
    assign bus.md_done       = md_done;
endmodule

// File: tb/tb_ctrl_pipe_stage.sv
`timescale 1ns/1ps
module tb_ctrl_pipe_stage;
    localparam int ALUOP_W    = 4;
    localparam int RADDR_W    = 5;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 16;

    localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                           A_OR  = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_LUI = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10;

    typedef struct packed {
        logic       valid;
        logic [3:0] aluop;
        logic       alusrc, regdst, regwrite, writemem, readmem, memtoreg, signextend, branch;
        logic [1:0] shift;
        logic [1:0] pc_source;
        logic [4:0] rt;
        logic [4:0] rd;
    } ex_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       md;
        ex_t        ctl;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst;
    int     errors = 0;
    int     checks = 0;
    instr_t table_q[$];
    int     pool_q[$];

    ctrl_pipe_stage_if #(.ALUOP_W(ALUOP_W), .RADDR_W(RADDR_W)) bus();

    ctrl_pipe_stage #(
        .ALUOP_W(ALUOP_W), .RADDR_W(RADDR_W),
        .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // bits = {alusrc, regdst, regwrite, writemem, readmem, memtoreg, signextend, branch}
    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] alu,
                                  input logic [7:0] bits, input logic [1:0] sh, input logic [1:0] pcs,
                                  input logic md);
        instr_t r;
        r.op = op; r.fn = fn; r.md = md;
        r.ctl = '0;
        r.ctl.valid = 1'b1;
        r.ctl.aluop = alu;
        {r.ctl.alusrc, r.ctl.regdst, r.ctl.regwrite, r.ctl.writemem,
         r.ctl.readmem, r.ctl.memtoreg, r.ctl.signextend, r.ctl.branch} = bits;
        r.ctl.shift = sh;
        r.ctl.pc_source = pcs;
        return r;
    endfunction

    task automatic build_table();
        table_q.push_back(mk(6'h00, 6'h20, A_ADD, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h21, A_ADD, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h22, A_SUB, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h23, A_SUB, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h24, A_AND, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h25, A_OR,  8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h27, A_NOR, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h2A, A_SLT, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h00, A_SLL, 8'b0110_0000, 2'b01, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h02, A_SRL, 8'b0110_0000, 2'b10, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h03, A_SRA, 8'b0110_0000, 2'b11, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h08, A_NOP, 8'b0000_0000, 2'b00, 2'b11, 1'b0));
        table_q.push_back(mk(6'h00, 6'h18, A_NOP, 8'b0000_0000, 2'b00, 2'b00, 1'b1));
        table_q.push_back(mk(6'h00, 6'h19, A_NOP, 8'b0000_0000, 2'b00, 2'b00, 1'b1));
        table_q.push_back(mk(6'h00, 6'h1A, A_NOP, 8'b0000_0000, 2'b00, 2'b00, 1'b1));
        table_q.push_back(mk(6'h00, 6'h1B, A_NOP, 8'b0000_0000, 2'b00, 2'b00, 1'b1));
        table_q.push_back(mk(6'h00, 6'h10, A_NOP, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h00, 6'h12, A_NOP, 8'b0110_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h08, 6'h00, A_ADD, 8'b1010_0010, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h09, 6'h00, A_ADD, 8'b1010_0010, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h0A, 6'h00, A_SLT, 8'b1010_0010, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h0C, 6'h00, A_AND, 8'b1010_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h0D, 6'h00, A_OR,  8'b1010_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h0F, 6'h00, A_LUI, 8'b1010_0000, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h23, 6'h00, A_ADD, 8'b1010_1110, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h2B, 6'h00, A_ADD, 8'b1001_0010, 2'b00, 2'b00, 1'b0));
        table_q.push_back(mk(6'h04, 6'h00, A_SUB, 8'b0000_0011, 2'b00, 2'b01, 1'b0));
        table_q.push_back(mk(6'h05, 6'h00, A_SUB, 8'b0000_0011, 2'b00, 2'b01, 1'b0));
        table_q.push_back(mk(6'h07, 6'h00, A_SUB, 8'b0000_0011, 2'b00, 2'b01, 1'b0));
        table_q.push_back(mk(6'h01, 6'h00, A_SUB, 8'b0000_0011, 2'b00, 2'b01, 1'b0));
        table_q.push_back(mk(6'h02, 6'h00, A_NOP, 8'b0000_0000, 2'b00, 2'b10, 1'b0));
        table_q.push_back(mk(6'h03, 6'h00, A_NOP, 8'b0010_0000, 2'b00, 2'b10, 1'b0));
        foreach (table_q[i]) if (!table_q[i].md) pool_q.push_back(i);
    endtask

    // Function field only matters for R-type instructions.
    function automatic int find_instr(input logic [5:0] op, input logic [5:0] fn);
        foreach (table_q[i])
            if (table_q[i].op == op && (op != 6'h00 || table_q[i].fn == fn)) return i;
        return -1;
    endfunction

    function automatic ex_t ref_ex(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] rt, input logic [4:0] rd);
        ex_t r;
        int  i = find_instr(op, fn);
        if (i < 0) return '0;
        r = table_q[i].ctl;
        r.rt = rt;
        r.rd = rd;
        return r;
    endfunction

    function automatic ex_t dut_ex();
        ex_t r;
        r.valid = bus.ex_valid;         r.aluop = bus.ex_aluop;
        r.alusrc = bus.ex_alusrc;       r.regdst = bus.ex_regdst;
        r.regwrite = bus.ex_regwrite;   r.writemem = bus.ex_writemem;
        r.readmem = bus.ex_readmem;     r.memtoreg = bus.ex_memtoreg;
        r.signextend = bus.ex_signextend; r.branch = bus.ex_branch;
        r.shift = bus.ex_shift;         r.pc_source = bus.ex_pc_source;
        r.rt = bus.ex_rt;               r.rd = bus.ex_rd;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl);
        bus.id_valid = v; bus.opcode = op; bus.func = fn;
        bus.id_rs = rs;   bus.id_rt = rt;  bus.id_rd = rd;
        bus.flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ex_t exp;
        rst = 1'b1;
        drive(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        step(); step();
        checks++; if (dut_ex() !== ex_t'(0)) begin errors++; $display("FAIL reset_ex: got %h expected 0", dut_ex()); end
        checks++; if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_md: busy=%b done=%b expected 0 0", bus.md_busy, bus.md_done); end
        rst = 1'b0;
        step();
        exp = '0;
        exp.valid = 1'b1; exp.aluop = A_ADD; exp.alusrc = 1'b1; exp.regwrite = 1'b1;
        exp.signextend = 1'b1; exp.rt = 5'd2; exp.rd = 5'd3;
        checks++; if (dut_ex() !== exp) begin errors++; $display("FAIL addi_after_reset: got %h expected %h", dut_ex(), exp); end
    endtask

    task automatic test_load_use(input logic [4:0] lw_rt);
        logic exp_stall = (lw_rt != 5'd0);
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0); step();
        drive(1'b1, 6'h23, 6'h00, 5'd1, lw_rt, 5'd9, 1'b0); step();
        drive(1'b1, 6'h00, 6'h20, lw_rt, 5'd2, 5'd3, 1'b0); #1;
        checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL lu_stall rt=%0d: got %b expected %b", lw_rt, bus.stall, exp_stall); end
        if (exp_stall) begin
            step();
            checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: ex_valid got %b expected 0", bus.ex_valid); end
            #1;
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b expected 0", bus.stall); end
        end
        step();
        checks++; if (dut_ex() !== ref_ex(6'h00, 6'h20, 5'd2, 5'd3)) begin errors++; $display("FAIL lu_add_in_ex rt=%0d: got %h expected %h", lw_rt, dut_ex(), ref_ex(6'h00, 6'h20, 5'd2, 5'd3)); end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_mul_mflo();
        drive(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0); step();
        checks++; if (dut_ex() !== ref_ex(6'h00, 6'h18, 5'd2, 5'd0)) begin errors++; $display("FAIL mult_in_ex: got %h expected %h", dut_ex(), ref_ex(6'h00, 6'h18, 5'd2, 5'd0)); end
        drive(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 1'b0);
        for (int k = 1; k <= MUL_CYCLES; k++) begin
            #1;
            checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL mul_busy c%0d: got %b expected 1", k, bus.md_busy); end
            checks++; if (bus.md_done !== (k == MUL_CYCLES)) begin errors++; $display("FAIL mul_done c%0d: got %b expected %b", k, bus.md_done, k == MUL_CYCLES); end
            checks++; if (bus.stall !== (k < MUL_CYCLES)) begin errors++; $display("FAIL mflo_stall c%0d: got %b expected %b", k, bus.stall, k < MUL_CYCLES); end
            if (k > 1) begin
                checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL mflo_bubble c%0d: got %b expected 0", k, bus.ex_valid); end
            end
            step();
        end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL mul_idle: got %b expected 0", bus.md_busy); end
        checks++; if (dut_ex() !== ref_ex(6'h00, 6'h12, 5'd0, 5'd4)) begin errors++; $display("FAIL mflo_in_ex: got %h expected %h", dut_ex(), ref_ex(6'h00, 6'h12, 5'd0, 5'd4)); end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_div_flush();
        int busy_cnt = 0, done_cnt = 0, done_at = -1, last_busy = -1;
        drive(1'b1, 6'h00, 6'h1A, 5'd1, 5'd2, 5'd0, 1'b0); step();
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b1);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 0) begin
                checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL div_flush_stall: got %b expected 0", bus.stall); end
            end
            if (bus.md_busy === 1'b1) begin busy_cnt++; last_busy = c; end
            if (bus.md_done === 1'b1) begin done_cnt++; done_at = c; end
            step();
            if (c == 0) begin
                checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL div_flush_bubble: got %b expected 0", bus.ex_valid); end
                drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
            end
        end
        checks++; if (busy_cnt != DIV_CYCLES) begin errors++; $display("FAIL div_busy_cycles: got %0d expected %0d", busy_cnt, DIV_CYCLES); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL div_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (done_at != last_busy) begin errors++; $display("FAIL div_done_position: got %0d expected %0d", done_at, last_busy); end
    endtask

    task automatic test_flush_load_use();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd6, 5'd0, 1'b0); step();
        drive(1'b1, 6'h00, 6'h20, 5'd6, 5'd2, 5'd3, 1'b1); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_lu_stall: got %b expected 0", bus.stall); end
        step();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_lu_bubble: got %b expected 0", bus.ex_valid); end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset_mid_md();
        int late = 0;
        drive(1'b1, 6'h00, 6'h1B, 5'd1, 5'd2, 5'd0, 1'b0); step();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (DIV_CYCLES - 1 - 7) step();
        #1;
        checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL rst_md_pre_busy: got %b expected 1", bus.md_busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin errors++; $display("FAIL rst_md_abort: busy=%b done=%b expected 0 0", bus.md_busy, bus.md_done); end
        #1 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL rst_md_quiet: %0d active cycles expected 0", late); end
    endtask

    task automatic test_unknown();
        drive(1'b1, 6'h0D, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0); step();
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL unk_pre_valid: got %b expected 1", bus.ex_valid); end
        drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0); step();
        checks++; if (dut_ex() !== ex_t'(0)) begin errors++; $display("FAIL unk_opcode: got %h expected 0", dut_ex()); end
        drive(1'b1, 6'h0D, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0); step();
        drive(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0); step();
        checks++; if (dut_ex() !== ex_t'(0)) begin errors++; $display("FAIL unk_func: got %h expected 0", dut_ex()); end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0); step();
    endtask

    // Random issue of non-MULT/DIV traffic; the model tracks what EX should hold
    // and replays the ID instruction whenever it expects a stall.
    task automatic test_random();
        ex_t        model_ex = '0, next_ex;
        logic       v = 1'b0, fl, held = 1'b0, urt, hz, exp_stall;
        logic [5:0] op = '0, fn = '0;
        logic [4:0] rs = '0, rt = '0, rd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                int pick = $urandom_range(0, 9);
                if (pick == 0)      begin op = 6'h3F; fn = 6'($urandom); end
                else if (pick == 1) begin op = 6'h00; fn = 6'h3F; end
                else if (pick <= 3) begin op = 6'h23; fn = 6'($urandom); end
                else begin
                    int i = pool_q[$urandom_range(0, pool_q.size() - 1)];
                    op = table_q[i].op;
                    fn = (op == 6'h00) ? table_q[i].fn : 6'($urandom);
                end
                rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom);
                v  = ($urandom_range(0, 4) != 0);
            end
            fl  = ($urandom_range(0, 7) == 0);
            urt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
            hz  = v && model_ex.valid && model_ex.readmem && (model_ex.rt != 0) &&
                  ((model_ex.rt == rs) || (urt && model_ex.rt == rt));
            exp_stall = hz && !fl;
            drive(v, op, fn, rs, rt, rd, fl); #1;
            checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d: got %b expected %b", n, bus.stall, exp_stall); end
            next_ex = (v && !fl && !exp_stall) ? ref_ex(op, fn, rt, rd) : ex_t'(0);
            held = exp_stall;
            step();
            checks++; if (dut_ex() !== next_ex) begin errors++; $display("FAIL rnd_ex n=%0d: got %h expected %h", n, dut_ex(), next_ex); end
            model_ex = next_ex;
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        build_table();
        test_reset();
        test_load_use(5'd5);
        test_load_use(5'd0);
        test_mul_mflo();
        test_div_flush();
        test_flush_load_use();
        test_reset_mid_md();
        test_unknown();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
